// File: rtl/stop_filter_pkg.sv
// Shared types and limits for the multi-channel stop filter.
package stop_filter_pkg;

  // Per-channel sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VALID  = 2'd1,
    ST_FINISH = 2'd2,
    ST_DEAD   = 2'd3
  } ch_state_e;

  // Smallest synchroniser that still resolves metastability.
  localparam int SYNC_MIN = 2;

  // Legal channel count range.
  localparam int N_CH_MIN = 1;
  localparam int N_CH_MAX = 32;

  // Width of the hold-off down-counter, which is loaded with dead_cycles-1.
  function automatic int dead_cnt_w(input int dead_cycles);
    return (dead_cycles > 2) ? $clog2(dead_cycles) : 1;
  endfunction

endpackage

// File: rtl/stop_filter_ch.sv
// One stop channel: hit-clocked capture flop, clk-domain synchroniser,
// IDLE/VALID/FINISH/DEAD sequencer and an optional saturating hit counter.
// Counter is built only when STOP_FILTER_HITCNT_EN is defined.
module stop_filter_ch
  import stop_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEAD_CYCLES = 4,
  parameter int HIT_POL     = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic             hit,
  output logic             filtered_hit,
  output logic             valid,
  output logic             finish,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int              DW        = dead_cnt_w(DEAD_CYCLES);
  localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  // A hold-off shorter than the synchroniser would let a stale level re-trigger.
  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("stop_filter_ch: SYNC_STAGES must be at least %0d", SYNC_MIN);
  end
  if (DEAD_CYCLES < SYNC_STAGES) begin : g_bad_dead
    $error("stop_filter_ch: DEAD_CYCLES must be at least SYNC_STAGES");
  end

  logic                   cap_clk;
  logic                   cap_clr;
  logic                   cap_d, cap_q;
  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  ch_state_e              state_d, state_q;
  logic [DW-1:0]          dead_cnt_d, dead_cnt_q;
  logic                   valid_d, valid_q;
  logic                   finish_d, finish_q;

  // Pick the active hit edge; the capture flop always clocks on a rising edge.
  if (HIT_POL != 0) begin : g_rise
    assign cap_clk = hit;
  end else begin : g_fall
    assign cap_clk = ~hit;
  end

  // The registered finish flag doubles as the clear strobe for the capture flop.
  assign cap_clr = rst | ~en | finish_q;

  // Capture input is a constant one; the edge itself is the event.
  always_comb begin
    cap_d = 1'b1;
  end

  // Capture flop lives in the hit domain and is only ever cleared asynchronously.
  always_ff @(posedge cap_clk or posedge cap_clr) begin
    if (cap_clr) cap_q <= 1'b0;
    else         cap_q <= cap_d;
  end

  // Shift the captured level into the clk domain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], cap_q};
  end

  // Synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign filtered_hit = sync_q[SYNC_STAGES-1];

  // Sequencer: accept, pulse valid, pulse finish and clear, then hold off.
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (filtered_hit) state_d = ST_VALID;
      end
      ST_VALID: begin
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d    = ST_DEAD;
        dead_cnt_d = DEAD_LOAD;
      end
      ST_DEAD: begin
        if (dead_cnt_q == '0) state_d = ST_IDLE;
        else                  dead_cnt_d = dead_cnt_q - DW'(1);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d  = (state_d == ST_VALID);
    finish_d = (state_d == ST_FINISH);
  end

  // Sequencer registers; outputs are registered so they launch cleanly on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dead_cnt_q <= '0;
      valid_q    <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      valid_q    <= valid_d;
      finish_q   <= finish_d;
    end
  end

  assign valid  = valid_q;
  assign finish = finish_q;

`ifdef STOP_FILTER_HITCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count accepted hits, saturating; a clear beats a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                       cnt_d = '0;
    else if (valid_q && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hit_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: rtl/stop_filter_mc.sv
// Multi-channel stop filter: N_CH independent stop_filter_ch instances plus
// a combined valid flag. Hit counters exist only with STOP_FILTER_HITCNT_EN.
module stop_filter_mc
  import stop_filter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEAD_CYCLES = 4,
  parameter int HIT_POL     = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cnt_clr,
  input  logic [N_CH-1:0]       hit,
  output logic [N_CH-1:0]       filtered_hit,
  output logic [N_CH-1:0]       valid,
  output logic [N_CH-1:0]       finish,
  output logic                  any_valid,
  output logic [N_CH*CNT_W-1:0] hit_cnt
);

  // Reject channel counts outside the supported range.
  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_nch
    $error("stop_filter_mc: N_CH must be within %0d..%0d", N_CH_MIN, N_CH_MAX);
  end

  // One fully independent channel per hit bit.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    stop_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEAD_CYCLES (DEAD_CYCLES),
      .HIT_POL     (HIT_POL),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .cnt_clr      (cnt_clr),
      .hit          (hit[k]),
      .filtered_hit (filtered_hit[k]),
      .valid        (valid[k]),
      .finish       (finish[k]),
      .hit_cnt      (hit_cnt[k*CNT_W +: CNT_W])
    );
  end

  // Channel valids are flops, so their OR is aligned with them.
  assign any_valid = |valid;

endmodule

// File: tb/tb_stop_filter_mc.sv
// Directed self-checking bench for stop_filter_mc: default build, a 2-bit
// counter build and a rising-edge build share one clock.
module tb_stop_filter_mc;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;
`ifdef STOP_FILTER_HITCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  logic                  en, cnt_clr;
  logic [N_CH-1:0]       hit, filtered_hit, valid, finish;
  logic                  any_valid;
  logic [N_CH*CNT_W-1:0] hit_cnt;

  logic                  sat_en, sat_cnt_clr;
  logic [N_CH-1:0]       sat_hit, sat_filtered_hit, sat_valid, sat_finish;
  logic                  sat_any_valid;
  logic [N_CH*SAT_W-1:0] sat_hit_cnt;

  logic                  pol_en, pol_cnt_clr;
  logic [N_CH-1:0]       pol_hit, pol_filtered_hit, pol_valid, pol_finish;
  logic                  pol_any_valid;
  logic [N_CH*CNT_W-1:0] pol_hit_cnt;

  int tests_run;
  int tests_failed;

  stop_filter_mc dut (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr), .hit(hit),
    .filtered_hit(filtered_hit), .valid(valid), .finish(finish),
    .any_valid(any_valid), .hit_cnt(hit_cnt)
  );

  stop_filter_mc #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .en(sat_en), .cnt_clr(sat_cnt_clr), .hit(sat_hit),
    .filtered_hit(sat_filtered_hit), .valid(sat_valid), .finish(sat_finish),
    .any_valid(sat_any_valid), .hit_cnt(sat_hit_cnt)
  );

  stop_filter_mc #(.HIT_POL(1)) dut_pol (
    .clk(clk), .rst(rst), .en(pol_en), .cnt_clr(pol_cnt_clr), .hit(pol_hit),
    .filtered_hit(pol_filtered_hit), .valid(pol_valid), .finish(pol_finish),
    .any_valid(pol_any_valid), .hit_cnt(pol_hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; cnt_clr = 1'b0; hit = 4'hF;
    sat_en = 1'b1; sat_cnt_clr = 1'b0; sat_hit = 4'hF;
    pol_en = 1'b1; pol_cnt_clr = 1'b0; pol_hit = 4'h0;
    tick(3);
    tests_run++;
    if ({valid, finish, filtered_hit, any_valid} !== 13'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {valid, finish, filtered_hit, any_valid});
    end
    tests_run++;
    if (hit_cnt !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hit_cnt: got %h expected 0", hit_cnt);
    end
    hit[0] = 1'b0;
    tick(4);
    tests_run++;
    if ({filtered_hit, valid} !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_holds_capture: got %h expected 0", {filtered_hit, valid});
    end
    hit[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    tests_run++;
    if ({valid, finish, filtered_hit, any_valid} !== 13'd0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_outputs: got %h expected 0", {valid, finish, filtered_hit, any_valid});
    end
    tests_run++;
    if ({sat_valid, pol_valid, sat_hit_cnt, pol_hit_cnt[CNT_W-1:0]} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_other: got %h expected 0", {sat_valid, pol_valid, sat_hit_cnt});
    end
  endtask

  task automatic test_single_hit();
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = CNT_ON ? 16'd1 : 16'd0;
    hit[0] = 1'b0;
    tick(2);
    tests_run++;
    if (filtered_hit !== 4'b0001 || valid !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL single_sync: got filt=%b valid=%b expected filt=0001 valid=0000", filtered_hit, valid);
    end
    tick(1);
    tests_run++;
    if (valid !== 4'b0001 || any_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_valid: got valid=%b any=%b expected 0001/1", valid, any_valid);
    end
    tick(1);
    tests_run++;
    if (valid !== 4'b0000 || finish !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL single_finish: got valid=%b finish=%b expected 0000/0001", valid, finish);
    end
    tests_run++;
    if (hit_cnt[CNT_W-1:0] !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL single_count: got %0d expected %0d", hit_cnt[CNT_W-1:0], exp_cnt);
    end
    tick(1);
    tests_run++;
    if (finish !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL single_finish_width: got %b expected 0000", finish);
    end
    hit[0] = 1'b1;
    tick(6);
  endtask

  task automatic test_double_edge();
    int n_valid, first_c, second_c;
    logic [CNT_W-1:0] exp_cnt;
    n_valid = 0; first_c = -1; second_c = -1;
    exp_cnt = CNT_ON ? 16'd2 : 16'd0;
    hit[1] = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick(1);
      if (valid[1]) begin
        n_valid++;
        if (n_valid == 1) first_c = c;
        else if (n_valid == 2) second_c = c;
      end
      if (c == 1) begin
        hit[1] = 1'b1;
        #1;
        hit[1] = 1'b0;
      end
      if (c == 6)  hit[1] = 1'b1;
      if (c == 10) hit[1] = 1'b0;
    end
    tests_run++;
    if (n_valid !== 2) begin
      tests_failed++;
      $display("[TB] FAIL double_valid_count: got %0d expected 2", n_valid);
    end
    tests_run++;
    if (first_c !== 3 || second_c !== 13) begin
      tests_failed++;
      $display("[TB] FAIL double_valid_cycles: got %0d,%0d expected 3,13", first_c, second_c);
    end
    tests_run++;
    if (hit_cnt[CNT_W +: CNT_W] !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL double_count: got %0d expected %0d", hit_cnt[CNT_W +: CNT_W], exp_cnt);
    end
    hit[1] = 1'b1;
    tick(2);
  endtask

  task automatic test_dead_rearm();
    int n_valid, first_c, second_c;
    n_valid = 0; first_c = -1; second_c = -1;
    hit[2] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick(1);
      if (valid[2]) begin
        n_valid++;
        if (n_valid == 1) first_c = c;
        else if (n_valid == 2) second_c = c;
      end
      if (c == 5) hit[2] = 1'b1;
      if (c == 6) hit[2] = 1'b0;
    end
    tests_run++;
    if (n_valid !== 2) begin
      tests_failed++;
      $display("[TB] FAIL dead_rearm_count: got %0d expected 2", n_valid);
    end
    tests_run++;
    if (first_c !== 3 || second_c !== 10) begin
      tests_failed++;
      $display("[TB] FAIL dead_rearm_cycles: got %0d,%0d expected 3,10", first_c, second_c);
    end
    hit[2] = 1'b1;
    tick(4);
  endtask

  task automatic test_all_channels();
    hit = 4'h0;
    tick(2);
    tests_run++;
    if (any_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL all_early: got any_valid=%b expected 0", any_valid);
    end
    tick(1);
    tests_run++;
    if (valid !== 4'hF || any_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL all_valid: got valid=%h any=%b expected F/1", valid, any_valid);
    end
    tick(1);
    tests_run++;
    if (finish !== 4'hF || any_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL all_finish: got finish=%h any=%b expected F/0", finish, any_valid);
    end
    hit = 4'hF;
    tick(8);
  endtask

  task automatic test_enable();
    logic [N_CH-1:0] seen;
    seen = '0;
    en = 1'b0;
    tick(1);
    hit[0] = 1'b0;
    tick(1);
    hit[0] = 1'b1;
    #1;
    hit[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      seen = seen | valid | filtered_hit;
    end
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      seen = seen | valid;
    end
    tests_run++;
    if (seen !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL enable_low_blocks: got %b expected 0000", seen);
    end
    hit[0] = 1'b1;
    hit[3] = 1'b0;
    tick(3);
    tests_run++;
    if (valid !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL enable_mid_valid: got %b expected 1000", valid);
    end
    en = 1'b0;
    tick(1);
    tests_run++;
    if (finish !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL enable_mid_finish: got %b expected 1000", finish);
    end
    en = 1'b1;
    hit[3] = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_mid();
    logic [N_CH-1:0] seen;
    seen = '0;
    hit[3] = 1'b0;
    tick(3);
    tests_run++;
    if (valid !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_valid: got %b expected 1000", valid);
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({valid, finish, filtered_hit, any_valid} !== 13'd0 || hit_cnt !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_async_clear: got %h cnt=%h expected 0", {valid, finish, filtered_hit, any_valid}, hit_cnt);
    end
    tick(1);
    seen = seen | finish;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      seen = seen | finish | valid;
    end
    tests_run++;
    if (seen !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_no_finish: got %b expected 0000", seen);
    end
    hit[3] = 1'b1;
    tick(2);
  endtask

  task automatic test_saturate();
    logic [SAT_W-1:0] exp_cnt;
    for (int i = 0; i < 5; i++) begin
      sat_hit[0] = 1'b0;
      tick(5);
      sat_hit[0] = 1'b1;
      tick(7);
      if (i == 1) begin
        exp_cnt = CNT_ON ? 2'd2 : 2'd0;
        tests_run++;
        if (sat_hit_cnt[SAT_W-1:0] !== exp_cnt) begin
          tests_failed++;
          $display("[TB] FAIL sat_count_two: got %0d expected %0d", sat_hit_cnt[SAT_W-1:0], exp_cnt);
        end
      end
    end
    exp_cnt = CNT_ON ? 2'd3 : 2'd0;
    tests_run++;
    if (sat_hit_cnt[SAT_W-1:0] !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL sat_count_max: got %0d expected %0d", sat_hit_cnt[SAT_W-1:0], exp_cnt);
    end
    sat_hit[0] = 1'b0;
    tick(3);
    tests_run++;
    if (sat_valid !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL sat_clr_valid: got %b expected 0001", sat_valid);
    end
    sat_cnt_clr = 1'b1;
    tick(1);
    sat_cnt_clr = 1'b0;
    tests_run++;
    if (sat_hit_cnt[SAT_W-1:0] !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL sat_clr_wins: got %0d expected 0", sat_hit_cnt[SAT_W-1:0]);
    end
    sat_hit[0] = 1'b1;
    tick(7);
    sat_hit[0] = 1'b0;
    tick(5);
    exp_cnt = CNT_ON ? 2'd1 : 2'd0;
    tests_run++;
    if (sat_hit_cnt[SAT_W-1:0] !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL sat_after_clr: got %0d expected %0d", sat_hit_cnt[SAT_W-1:0], exp_cnt);
    end
    sat_hit[0] = 1'b1;
    tick(6);
  endtask

  task automatic test_polarity();
    logic [N_CH-1:0] seen;
    seen = '0;
    pol_en = 1'b0;
    tick(1);
    pol_hit[0] = 1'b1;
    tick(2);
    pol_en = 1'b1;
    tick(2);
    pol_hit[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      seen = seen | pol_valid;
    end
    tests_run++;
    if (seen !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL pol_falling_ignored: got %b expected 0000", seen);
    end
    pol_hit[0] = 1'b1;
    tick(2);
    tests_run++;
    if (pol_valid !== 4'b0000 || pol_filtered_hit !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL pol_sync: got valid=%b filt=%b expected 0000/0001", pol_valid, pol_filtered_hit);
    end
    tick(1);
    tests_run++;
    if (pol_valid !== 4'b0001 || pol_any_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pol_rising_valid: got valid=%b any=%b expected 0001/1", pol_valid, pol_any_valid);
    end
    pol_hit[0] = 1'b0;
    tick(8);
  endtask

  // Run every scenario in order, then report.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_hit();
    test_double_edge();
    test_dead_rearm();
    test_all_channels();
    test_enable();
    test_reset_mid();
    test_saturate();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/stop_filter_mc.md
STOP_FILTER_MC -- requirements
Module: stop_filter_mc

Interface
REQ-001 Parameter N_CH, default 4: number of independent stop channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth in clk cycles (min 2).
REQ-003 Parameter DEAD_CYCLES, default 4: per-channel re-arm hold-off after finish (min SYNC_STAGES).
REQ-004 Parameter HIT_POL, default 0: 0 = capture on hit falling edge, 1 = capture on rising edge.
REQ-005 Parameter CNT_W, default 16: width of each hit counter.
REQ-006 Port clk, input, 1: single system clock, all outputs launched on rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port en, input, 1: global arm; low holds every capture flop cleared.
REQ-009 Port cnt_clr, input, 1: synchronous clear of all hit counters.
REQ-010 Port hit, input, N_CH: asynchronous stop pulses, one bit per channel.
REQ-011 Port filtered_hit, output, N_CH: synchronised captured level per channel.
REQ-012 Port valid, output, N_CH: one-cycle pulse per accepted hit.
REQ-013 Port finish, output, N_CH: one-cycle pulse, one cycle after valid.
REQ-014 Port any_valid, output, 1: OR of valid bits, registered with valid.
REQ-015 Port hit_cnt, output, N_CH*CNT_W: per-channel accepted-hit counts, channel k at bits [k*CNT_W +: CNT_W].

Function
REQ-016 Each channel SHALL capture the selected hit edge in a flop clocked by hit (inverted when HIT_POL=0) with D=1, independent of clk.
REQ-017 The capture flop SHALL be cleared asynchronously by rst, by en low, or by the channel clear strobe (registered, high in FINISH state).
REQ-018 Capture output SHALL pass through SYNC_STAGES clk flops; last stage drives filtered_hit.
REQ-019 Channel FSM states: IDLE, VALID, FINISH, DEAD.
REQ-020 IDLE -> VALID when filtered_hit=1; valid=1 only in VALID.
REQ-021 VALID -> FINISH unconditionally; finish=1 only in FINISH; clear strobe asserted in FINISH.
REQ-022 FINISH -> DEAD; DEAD counts DEAD_CYCLES cycles, then -> IDLE.
REQ-023 Latency: capture edge to valid = SYNC_STAGES+1 clk edges (+1 if edge violates setup of stage 1).
REQ-024 Hit edges while capture flop already set SHALL be ignored (no second valid).
REQ-025 Hit edges during DEAD after the clear strobe deasserts SHALL be captured and produce valid after DEAD exits.
REQ-026 filtered_hit levels still high on DEAD exit SHALL NOT occur (guaranteed by DEAD_CYCLES >= SYNC_STAGES).
REQ-027 en low mid-sequence: FSM completes current VALID/FINISH/DEAD sequence; no new capture until en high.
REQ-028 Channels SHALL be fully independent; simultaneous hits on all channels each produce valid in the same cycle.
REQ-029 hit_cnt[k] SHALL increment on valid[k], saturate at 2^CNT_W-1; cnt_clr wins over simultaneous increment.

Reset
REQ-030 rst SHALL asynchronously clear capture flops, synchronisers, counters, FSMs to IDLE.
REQ-031 All outputs SHALL be 0 during and after reset until a new captured hit.
REQ-032 Reset mid-sequence SHALL abort it with no finish pulse emitted.

Configuration
REQ-033 Macro STOP_FILTER_HITCNT_EN: defined -> hit counters built as REQ-029.
REQ-034 Undefined -> no counter logic; hit_cnt tied to 0; cnt_clr ignored.

Structure
REQ-035 Package stop_filter_pkg SHALL hold the FSM state typedef and minimum-value constants (SYNC_MIN=2).
REQ-036 Sub-module stop_filter_ch SHALL implement one channel (capture, sync, FSM, counter); top generates N_CH copies and any_valid.
REQ-037 Elaboration SHALL fail if DEAD_CYCLES < SYNC_STAGES or SYNC_STAGES < 2.

Verification
REQ-038 Defaults, single falling edge on hit[0] -> valid[0] 3 cycles later, finish[0] 1 cycle after, hit_cnt[0]=1.
REQ-039 Two hit[1] edges 1 clk apart -> exactly one valid[1]; second edge 10 cycles later -> second valid, count 2.
REQ-040 Edges on all 4 channels same instant -> valid=4'hF and any_valid=1 in one cycle.
REQ-041 CNT_W=2, 5 hits -> hit_cnt saturates at 3; cnt_clr with concurrent valid -> 0.
REQ-042 en=0 with hits -> no valid; rst asserted in VALID -> no finish, all outputs 0.
REQ-043 HIT_POL=1, rising edge only -> valid; falling edge alone -> none.
